alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single datapath ALU between two requesters: req0 is the main pipeline execute stage and req1 is the address-generation/branch helper. The block round-robin arbitrates, registers the winner's operands and 4-bit ALUControl code, and drives the ALU for one cycle. It captures the result and returns it on a shared valid/ready response channel tagged with the requester ID. It sits between the requesters and the combinational ALU that consumes the decoder's ALUControl encoding.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0_valid, req1_valid  in  1  requester N has an operation pending
- req0_ready, req1_ready  out  1  requester N's operation accepted this cycle (combinational)
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands
- req0_ctrl, req1_ctrl  in  4  ALUControl code
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_ctrl  out  4  registered ALUControl to ALU
- alu_en  out  1  high during the EXEC cycle only
- alu_result  in  WIDTH  combinational ALU output
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accepts
- rsp_id  out  1  requester that owns the response
- rsp_data  out  WIDTH  result
- rsp_err  out  1  unsupported ALUControl code

## Operation
- States: IDLE, EXEC, RESP. Reset state: IDLE.
- IDLE: grant is computed combinationally. If only one valid is high, that requester wins. If both are high, the requester indicated by the priority pointer wins. reqN_ready = (state==IDLE) & grant==N; at most one ready is high per cycle.
- On acceptance, latch a/b/ctrl into alu_a/alu_b/alu_ctrl, store the owner ID, and set the pointer to the other requester. Then go to EXEC. A cycle with no acceptance leaves the pointer unchanged.
- Valid ALUControl codes are 4'b0000–4'b1000: add, sub, and, or, xor, slt, sra, srl, sll.
- Codes 4'b1001–4'b1111 are still accepted, but are marked illegal at latch. In EXEC, alu_en stays 0, rsp_data is loaded with 0 and rsp_err with 1.
- EXEC: for a legal code, alu_en=1 and alu_result is captured into rsp_data with rsp_err=0. rsp_id is loaded with the owner. Always go to RESP.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_valid & rsp_ready, then go to IDLE.
- No requester is accepted outside IDLE, even if rsp_ready is high in RESP. The block is non-pipelined and holds one operation in flight.
- The block never alters the result. Width, wrap-around and sign semantics are entirely the ALU's; rsp_data equals alu_result bit-for-bit.
- alu_a, alu_b and alu_ctrl hold their last latched values outside EXEC. Only alu_en qualifies them.

## Timing
- Reset values: state IDLE, pointer=0 (req0 has priority), alu_a/alu_b/alu_ctrl/rsp_data=0, alu_en/rsp_valid/rsp_id/rsp_err=0.
- reqN_ready is 0 while reset is asserted.
- Accept in cycle T (valid & ready) → alu_en high in T+1 → rsp_valid high from T+2.
- If rsp_ready is high in T+2, the block returns to IDLE in T+3. The next acceptance is possible at T+3, so minimum spacing is 3 cycles per operation.
- rsp_ready low: rsp_valid and all rsp_* fields stay constant indefinitely, and both reqN_ready stay 0.
- Requester dropping valid before ready: nothing is latched and the pointer is unchanged. Requesters must hold valid and operands until ready.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded with no response. All outputs go to reset values asynchronously.
- Simultaneous valids every IDLE cycle: grants alternate 0,1,0,1,… starting from req0 after reset.

## Test plan
- Reset, then req0 add: a=5, b=3, ctrl=0000, rsp_ready=1.
  → req0_ready in cycle 1, alu_en in cycle 2, rsp_valid in cycle 3 with data=8, id=0, err=0.
- Both requesters valid continuously with distinct operands, rsp_ready=1.
  → grant order 0,1,0,1; each response id matches its operands; 3-cycle spacing.
- req1 sub: a=0, b=1, ctrl=0001, with the ALU model.
  → rsp_data=32'hFFFFFFFF, id=1, unchanged from alu_result.
- rsp_ready held low 5 cycles after rsp_valid while req0_valid=1.
  → rsp_* stable; req0_ready stays 0; accepted in the cycle after rsp_ready rises.
- req0 ctrl=4'b1010.
  → alu_en never asserts; rsp_valid with data=0, err=1, id=0.
- Assert reset during EXEC.
  → alu_en, rsp_valid and all outputs go 0 immediately; no response after release; the next simultaneous request grants req0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request, ALU-drive and response signals shared between the ALU arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the environment (requesters, ALU, consumer).
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_ctrl;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_ctrl;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic             alu_en;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_ctrl, alu_en,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_ctrl, alu_en,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: accept (IDLE) -> drive ALU (EXEC) -> hold response (RESP).
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    localparam int unsigned CTRL_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Highest ALUControl code the ALU implements (sll).
    localparam logic [CTRL_W-1:0] CTRL_MAX = 4'b1000;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic              r_ptr;
    logic              r_owner;
    logic              r_illegal;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic              r_alu_en;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_rsp_err;

    logic              w_any_valid;
    logic              w_grant;
    logic              w_accept;
    logic              w_rsp_done;
    logic [WIDTH-1:0]  w_sel_a;
    logic [WIDTH-1:0]  w_sel_b;
    logic [CTRL_W-1:0] w_sel_ctrl;
    logic              w_sel_illegal;

    // Grant: a lone requester wins outright; a tie goes to the pointer.
    always_comb begin
        w_any_valid = bus.req0_valid | bus.req1_valid;
        w_grant     = 1'b0;
        if (bus.req0_valid & bus.req1_valid) begin
            w_grant = r_ptr;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
        w_accept      = (r_state == S_IDLE) & w_any_valid & ~reset;
        w_rsp_done    = r_rsp_valid & bus.rsp_ready;
        w_sel_a       = w_grant ? bus.req1_a    : bus.req0_a;
        w_sel_b       = w_grant ? bus.req1_b    : bus.req0_b;
        w_sel_ctrl    = w_grant ? bus.req1_ctrl : bus.req0_ctrl;
        w_sel_illegal = (w_sel_ctrl > CTRL_MAX);
    end

    assign bus.req0_ready = w_accept & ~w_grant;
    assign bus.req1_ready = w_accept &  w_grant;

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latch, ALU enable and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_illegal   <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_ctrl  <= '0;
            r_alu_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= w_sel_a;
                r_alu_b    <= w_sel_b;
                r_alu_ctrl <= w_sel_ctrl;
                r_owner    <= w_grant;
                r_ptr      <= ~w_grant;
                r_illegal  <= w_sel_illegal;
                r_alu_en   <= ~w_sel_illegal;
            end else begin
                r_alu_en   <= 1'b0;
            end

            // Illegal codes never look at the ALU: they return zero with the error flag.
            if (r_state == S_EXEC) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_owner;
                r_rsp_data  <= r_illegal ? '0 : bus.alu_result;
                r_rsp_err   <= r_illegal;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.alu_en    = r_alu_en;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;

    // Protocol invariants.
    a_one_ready: assert property (@(posedge clk) disable iff (reset)
        !(bus.req0_ready && bus.req1_ready));
    a_ready_idle: assert property (@(posedge clk) disable iff (reset)
        (bus.req0_ready || bus.req1_ready) |-> (r_state == S_IDLE));
    a_rsp_hold: assert property (@(posedge clk) disable iff (reset)
        (bus.rsp_valid && !bus.rsp_ready) |=>
            (bus.rsp_valid && $stable(bus.rsp_data) && $stable(bus.rsp_id) && $stable(bus.rsp_err)));
    a_en_exec: assert property (@(posedge clk) disable iff (reset)
        bus.alu_en |-> (r_state == S_EXEC));
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by randomized traffic
// with random response back-pressure, checked against a transaction-level model.
module tb_alu_arbiter;
    localparam int unsigned WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       ctrl;
    } op_t;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
        logic             err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   checking = 1'b0;
    bit   rr_mode  = 1'b0;
    bit   rr_fixed = 1'b1;

    op_t  q0[$];
    op_t  q1[$];
    rsp_t sb[$];
    int   g_id[$];
    int   g_cyc[$];
    int   hs_cyc[$];
    int   n_rsp = 0;
    rsp_t last_rsp;

    // model state
    bit   m_busy = 1'b0;
    int   m_age  = 0;
    bit   m_prio = 1'b0;
    bit   m_legal;
    op_t  m_op;
    bit   m_acc;
    bit   m_win;

    // monitor state
    bit   hold = 1'b0;
    rsp_t held;
    rsp_t exp_r;

    always @(posedge clk) cyc++;

    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [3:0] c);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
            4'd6:    return WIDTH'($signed(a) >>> b[4:0]);
            4'd7:    return a >> b[4:0];
            4'd8:    return a << b[4:0];
            default: return WIDTH'(32'hDEAD_BEEF);
        endcase
    endfunction

    // Stand-in for the external combinational ALU.
    assign bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_ctrl);

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.a    = WIDTH'($urandom);
        o.b    = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 40)) : WIDTH'($urandom);
        o.ctrl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        return o;
    endfunction

    // Requester 0: present head of queue, hold until accepted.
    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
        forever begin
            @(posedge clk); #1;
            if (reset || q0.size() == 0) begin
                bus.req0_valid = 1'b0;
            end else begin
                bus.req0_valid = 1'b1;
                bus.req0_a = q0[0].a; bus.req0_b = q0[0].b; bus.req0_ctrl = q0[0].ctrl;
            end
            @(negedge clk);
            if (bus.req0_valid && bus.req0_ready) void'(q0.pop_front());
        end
    end

    // Requester 1.
    initial begin
        bus.req1_valid = 1'b0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
        forever begin
            @(posedge clk); #1;
            if (reset || q1.size() == 0) begin
                bus.req1_valid = 1'b0;
            end else begin
                bus.req1_valid = 1'b1;
                bus.req1_a = q1[0].a; bus.req1_b = q1[0].b; bus.req1_ctrl = q1[0].ctrl;
            end
            @(negedge clk);
            if (bus.req1_valid && bus.req1_ready) void'(q1.pop_front());
        end
    end

    // Response consumer.
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.rsp_ready = rr_mode ? ($urandom_range(0, 3) != 0) : rr_fixed;
        end
    end

    // Reference model: one op in flight; accept -> enable next cycle -> response the cycle after.
    always @(negedge clk) begin
        if (checking) begin
            if (reset) begin
                chk("ready0_in_reset", bus.req0_ready, 0);
                chk("ready1_in_reset", bus.req1_ready, 0);
                chk("alu_en_in_reset", bus.alu_en, 0);
                chk("rsp_valid_in_reset", bus.rsp_valid, 0);
                m_busy = 1'b0;
                m_prio = 1'b0;
                sb.delete();
            end else begin
                m_acc = 1'b0;
                m_win = 1'b0;
                if (!m_busy && (bus.req0_valid || bus.req1_valid)) begin
                    m_acc = 1'b1;
                    m_win = (bus.req0_valid && bus.req1_valid) ? m_prio : bus.req1_valid;
                end
                chk("req0_ready", bus.req0_ready, m_acc && !m_win);
                chk("req1_ready", bus.req1_ready, m_acc && m_win);
                if (m_busy && m_age == 1) begin
                    chk("alu_a", bus.alu_a, m_op.a);
                    chk("alu_b", bus.alu_b, m_op.b);
                    chk("alu_ctrl", bus.alu_ctrl, m_op.ctrl);
                end
                chk("alu_en", bus.alu_en, m_busy && m_age == 1 && m_legal);
                chk("rsp_valid", bus.rsp_valid, m_busy && m_age >= 2);
                if (m_busy) begin
                    if (m_age >= 2 && bus.rsp_ready) m_busy = 1'b0;
                    else m_age++;
                end
                if (m_acc) begin
                    if (m_win) m_op = '{a: bus.req1_a, b: bus.req1_b, ctrl: bus.req1_ctrl};
                    else       m_op = '{a: bus.req0_a, b: bus.req0_b, ctrl: bus.req0_ctrl};
                    m_legal = (m_op.ctrl <= 4'd8);
                    sb.push_back('{id: m_win, data: m_legal ? ref_alu(m_op.a, m_op.b, m_op.ctrl) : '0,
                                   err: !m_legal});
                    m_prio = !m_win;
                    m_busy = 1'b1;
                    m_age  = 1;
                    g_id.push_back(int'(m_win));
                    g_cyc.push_back(cyc);
                end
            end
        end
    end

    // Monitor: pop and compare on each response handshake; check stability while stalled.
    always @(negedge clk) begin
        if (!checking || reset) begin
            hold = 1'b0;
        end else if (bus.rsp_valid) begin
            if (hold) begin
                chk("stall_id", bus.rsp_id, held.id);
                chk("stall_data", bus.rsp_data, held.data);
                chk("stall_err", bus.rsp_err, held.err);
            end
            if (bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rsp_unexpected: got id=%0d data=%h with no operation outstanding",
                             bus.rsp_id, bus.rsp_data);
                end else begin
                    exp_r = sb.pop_front();
                    chk("rsp_id", bus.rsp_id, exp_r.id);
                    chk("rsp_data", bus.rsp_data, exp_r.data);
                    chk("rsp_err", bus.rsp_err, exp_r.err);
                end
                last_rsp = '{id: bus.rsp_id, data: bus.rsp_data, err: bus.rsp_err};
                hs_cyc.push_back(cyc);
                n_rsp++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
                held = '{id: bus.rsp_id, data: bus.rsp_data, err: bus.rsp_err};
            end
        end else begin
            hold = 1'b0;
        end
    end

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_busy || sb.size() != 0) && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (q0.size() != 0 || q1.size() != 0 || m_busy || sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_alu_a"}, bus.alu_a, '0);
        chk({tag, "_alu_b"}, bus.alu_b, '0);
        chk({tag, "_alu_ctrl"}, bus.alu_ctrl, '0);
        chk({tag, "_alu_en"}, bus.alu_en, '0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, '0);
        chk({tag, "_rsp_id"}, bus.rsp_id, '0);
        chk({tag, "_rsp_data"}, bus.rsp_data, '0);
        chk({tag, "_rsp_err"}, bus.rsp_err, '0);
        chk({tag, "_ready0"}, bus.req0_ready, '0);
        chk({tag, "_ready1"}, bus.req1_ready, '0);
    endtask

    initial begin
        int base;
        int k;
        int n_before;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        check_all_zero("reset");
        @(posedge clk); #2;
        reset = 1'b0;

        // req0 add 5+3
        q0.push_back('{a: 32'd5, b: 32'd3, ctrl: 4'b0000});
        wait_idle(20);
        chk("add_data", last_rsp.data, 32'd8);
        chk("add_id", last_rsp.id, 0);
        chk("add_err", last_rsp.err, 0);
        chk("add_latency", WIDTH'(hs_cyc[hs_cyc.size()-1] - g_cyc[g_cyc.size()-1]), 32'd2);

        // req1 sub 0-1
        q1.push_back('{a: 32'd0, b: 32'd1, ctrl: 4'b0001});
        wait_idle(20);
        chk("sub_data", last_rsp.data, 32'hFFFF_FFFF);
        chk("sub_id", last_rsp.id, 1);

        // both requesters continuously valid
        base = g_id.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{a: WIDTH'(100 + i), b: WIDTH'(i), ctrl: 4'b0000});
            q1.push_back('{a: WIDTH'(200 + i), b: WIDTH'(7), ctrl: 4'b0100});
        end
        wait_idle(60);
        for (int i = 0; i < 4; i++) chk("rr_order", WIDTH'(g_id[base+i]), WIDTH'(i % 2));
        for (int i = 1; i < 8; i++) chk("rr_spacing", WIDTH'(g_cyc[base+i] - g_cyc[base+i-1]), 32'd3);

        // back-pressure: rsp_ready low while req0 keeps requesting
        rr_fixed = 1'b0;
        q0.push_back('{a: 32'd7, b: 32'd9, ctrl: 4'b0000});
        k = 0;
        while (!bus.rsp_valid && k < 10) begin @(negedge clk); #1; k++; end
        chk("stall_rsp_seen", bus.rsp_valid, 1);
        q0.push_back('{a: 32'h8000_0000, b: 32'd4, ctrl: 4'b0110});
        repeat (5) @(negedge clk);
        rr_fixed = 1'b1;
        wait_idle(30);
        chk("stall_next_accept", WIDTH'(g_cyc[g_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]), 32'd1);
        chk("sra_data", last_rsp.data, 32'hF800_0000);

        // unsupported ALUControl code
        q0.push_back('{a: 32'd1, b: 32'd2, ctrl: 4'b1010});
        wait_idle(20);
        chk("illegal_data", last_rsp.data, 32'd0);
        chk("illegal_err", last_rsp.err, 1);
        chk("illegal_id", last_rsp.id, 0);

        // reset in the middle of EXEC
        q0.push_back('{a: 32'd11, b: 32'd22, ctrl: 4'b0000});
        k = 0;
        while (!bus.alu_en && k < 10) begin @(negedge clk); k++; end
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("exec_reset");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        n_before = n_rsp;
        repeat (4) @(negedge clk);
        chk("no_rsp_after_reset", WIDTH'(n_rsp), WIDTH'(n_before));
        base = g_id.size();
        q0.push_back('{a: 32'd3, b: 32'd4, ctrl: 4'b0011});
        q1.push_back('{a: 32'd5, b: 32'd6, ctrl: 4'b0010});
        wait_idle(30);
        chk("post_reset_grant", WIDTH'(g_id[base]), 32'd0);

        // randomized traffic with random back-pressure
        rr_mode = 1'b1;
        repeat (400) begin
            @(posedge clk);
            if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
            if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
        end
        rr_mode = 1'b0;
        wait_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
